line_raster_engine: RTL

//  Parametrised Bresenham line rasteriser for the MTL display path; successor to the single-line scanline plotter.

---
 rtl/line_raster_engine.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/line_raster_engine.sv
// -----------------------------------------------------------------------------
// line_raster_engine
//
// Bresenham line rasteriser. Line commands (two endpoints plus a colour) are
// queued in a small command FIFO. Each command is drawn in any octant and the
// result is streamed out one pixel per cycle over a valid/ready handshake.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset (FIFO, FSM and outputs cleared)
//   i_abort      synchronous flush: drops the queued commands and the current line
//   i_cmd_valid  command offered          o_cmd_ready  FIFO not full
//   i_cmd_x0/y0  start point              i_cmd_x1/y1  end point
//   i_cmd_color  line colour (passed through unchanged)
//   o_pix_valid  pixel presented          i_pix_ready  downstream accepts pixel
//   o_pix_x/y    pixel coordinate         o_pix_color  pixel colour
//   o_pix_last   pixel is the line end point
//   o_line_done  one-cycle pulse the cycle after the last pixel is accepted
//   o_busy       a line is in progress or commands are queued
// -----------------------------------------------------------------------------
module line_raster_engine #(
    parameter int XW        = 11,
    parameter int YW        = 10,
    parameter int CW        = 24,
    parameter int CMD_DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_abort,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [XW-1:0] i_cmd_x0,
    input  logic [YW-1:0] i_cmd_y0,
    input  logic [XW-1:0] i_cmd_x1,
    input  logic [YW-1:0] i_cmd_y1,
    input  logic [CW-1:0] i_cmd_color,
    output logic          o_pix_valid,
    input  logic          i_pix_ready,
    output logic [XW-1:0] o_pix_x,
    output logic [YW-1:0] o_pix_y,
    output logic [CW-1:0] o_pix_color,
    output logic          o_pix_last,
    output logic          o_line_done,
    output logic          o_busy
);

    // Signed working width: one extra bit for the sign, one for 2*err headroom.
    localparam int W  = ((XW > YW) ? XW : YW) + 2;
    localparam int AW = $clog2(CMD_DEPTH);

    typedef struct packed {
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] x1;
        logic [YW-1:0] y1;
        logic [CW-1:0] color;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN} state_t;

    // ---------------- command FIFO ----------------
    cmd_t          r_mem [CMD_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    cmd_t          w_head;

    // Extra pointer bit distinguishes full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Readiness is plain !full: a pop in the same cycle does not open a slot.
    assign w_push  = i_cmd_valid && !w_full && !i_abort;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= '{x0: i_cmd_x0, y0: i_cmd_y0,
                                         x1: i_cmd_x1, y1: i_cmd_y1,
                                         color: i_cmd_color};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // ---------------- FSM ----------------
    state_t r_state;
    state_t w_state_next;
    logic   w_pix_valid;
    logic   w_last;
    logic   w_accept;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] r_x1;
    logic [YW-1:0] r_y1;
    logic [CW-1:0] r_color;

    assign w_pix_valid = (r_state == S_RUN);
    assign w_last      = w_pix_valid && (r_x == r_x1) && (r_y == r_y1);
    assign w_accept    = w_pix_valid && i_pix_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: w_state_next = S_RUN;
            S_RUN:   if (w_accept && w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (i_abort) begin
            w_pop        = 1'b0;
            w_state_next = S_IDLE;
        end
    end

    // ---------------- Bresenham datapath ----------------
    logic signed [W-1:0] r_dx;     // |x1-x0|
    logic signed [W-1:0] r_dy;     // -|y1-y0|
    logic signed [W-1:0] r_err;
    logic                r_sx_pos; // x steps +1 when set, -1 otherwise
    logic                r_sy_pos;
    logic                r_line_done;

    logic signed [W-1:0] w_xs, w_x1s, w_ys, w_y1s;
    logic signed [W-1:0] w_dx, w_dy;
    logic signed [W:0]   w_e2;
    logic                w_step_x, w_step_y;
    logic signed [W-1:0] w_err_next;

    assign w_xs  = $signed({{(W-XW){1'b0}}, r_x});
    assign w_x1s = $signed({{(W-XW){1'b0}}, r_x1});
    assign w_ys  = $signed({{(W-YW){1'b0}}, r_y});
    assign w_y1s = $signed({{(W-YW){1'b0}}, r_y1});
    assign w_dx  = (w_x1s >= w_xs) ? (w_x1s - w_xs) : (w_xs - w_x1s);
    assign w_dy  = (w_y1s >= w_ys) ? (w_ys - w_y1s) : (w_y1s - w_ys);

    // Both axis decisions use the same e2, so a diagonal step happens in one cycle.
    assign w_e2       = {r_err, 1'b0};
    assign w_step_x   = (w_e2 >= $signed({r_dy[W-1], r_dy}));
    assign w_step_y   = (w_e2 <= $signed({r_dx[W-1], r_dx}));
    assign w_err_next = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_color     <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_err       <= '0;
            r_sx_pos    <= 1'b0;
            r_sy_pos    <= 1'b0;
            r_line_done <= 1'b0;
        end else begin
            r_line_done <= w_accept && w_last && !i_abort;
            if (w_pop) begin
                // Start point loads straight into the pixel position registers.
                r_x     <= w_head.x0;
                r_y     <= w_head.y0;
                r_x1    <= w_head.x1;
                r_y1    <= w_head.y1;
                r_color <= w_head.color;
            end
            if (r_state == S_SETUP && !i_abort) begin
                r_dx     <= w_dx;
                r_dy     <= w_dy;
                r_err    <= w_dx + w_dy;
                r_sx_pos <= (r_x1 >= r_x);
                r_sy_pos <= (r_y1 >= r_y);
            end
            if (w_accept && !w_last && !i_abort) begin
                r_err <= w_err_next;
                if (w_step_x) r_x <= r_sx_pos ? r_x + XW'(1) : r_x - XW'(1);
                if (w_step_y) r_y <= r_sy_pos ? r_y + YW'(1) : r_y - YW'(1);
            end
        end
    end

    assign o_cmd_ready = !w_full;
    assign o_pix_valid = w_pix_valid;
    assign o_pix_x     = r_x;
    assign o_pix_y     = r_y;
    assign o_pix_color = r_color;
    assign o_pix_last  = w_last;
    assign o_line_done = r_line_done;
    assign o_busy      = (r_state != S_IDLE) || !w_empty;

endmodule
